dff_async: RTL and testbench
============================

Name: dff_async

Overview:
- Parameterizable D flip-flop with a synchronous, active-high reset. It is the basic single-stage storage element for registering control and data bits.
- The default configuration is a 1-bit register that resets to 0.
- It is a leaf cell. It has no handshake and no internal state beyond Q.
- The "async" in the name is historical only. The reset is synchronous.

Parameters:
- WIDTH, 1, bit width of D and Q (must be >= 1)
- RST_VAL, {WIDTH{1'b0}}, value loaded into Q when reset is sampled high

Ports:
- clk  input  1  system clock; all state changes on the rising edge only
- reset  input  1  synchronous reset, active-high
- D  input  WIDTH  data input, sampled on the rising edge of clk
- Q  output  WIDTH  registered output, driven directly from the flop

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- On each rising edge of clk:
  - reset==1: Q <= RST_VAL.
  - reset==0: Q <= D.
- Reset has priority over D.
- There is no clock-enable. Q is reloaded on every edge.
- Latency is exactly 1 cycle: the D value sampled at edge n appears on Q just after edge n and holds until edge n+1.
- Reset is fully synchronous:
  - Asserting or deasserting reset between edges has no effect on Q until the next rising edge.
  - Q must not change on a reset edge alone, nor on a falling clk edge.
- Reset mid-operation: whatever Q held is overwritten with RST_VAL at the first rising edge that samples reset==1.
- Reset deassertion: the first rising edge that samples reset==0 loads D. There is no extra recovery cycle.
- Power-up: Q is unknown (X in simulation) until the first rising edge. No initial value is given, and the bench must not check Q before that edge.
- Glitches on D or reset between edges are ignored. Only the value present at the rising edge, with setup met, matters.
- Q is a pure register output with no combinational path from D or reset to Q.
- Width rule: D, Q and RST_VAL are all exactly WIDTH bits, with no extension or truncation.
- Synthesis result: WIDTH flops with synchronous reset (or set, per bit of RST_VAL) and no latches.

Decomposition:
- No shared package is needed. The block has no typedefs, and its only constants are the two parameters.
- No sub-modules. The block is a single always-at-posedge-clk process.
- Wider configurations are obtained by setting WIDTH, not by instantiating multiple 1-bit copies.
- The verification bench carries the bulk of the effort:
  - a golden reference model
  - randomized D/reset stimulus
  - assertions on 1-cycle latency and reset priority
  - a scoreboard

Test Plan:
- Reset load: WIDTH=1, Q preloaded to 1 (D=1, reset=0, one edge); hold reset=1, D=1 across an edge -> Q=0 after that edge; Q stays 0 on subsequent edges while reset=1.
- Release: reset=1 for 2 edges, then reset=0 with D=1 before the next edge -> Q=1 right after that edge, not earlier, not later.
- Sync-only check: clk period 4 ns; with Q=1, pulse reset=1 for 1 ns between two rising edges -> Q stays 1 throughout; Q unchanged on the falling edge.
- Alternating reset: with D=1 held, set reset to 1,0,1,0 on successive edges -> Q sequence 0,1,0,1, one cycle after each reset value.
- Data tracking: reset=0; D sequence 1,0,0,1 on successive edges -> Q shows 1,0,0,1, each delayed by exactly one edge; mid-cycle D changes are not visible on Q.
- Parameterized: WIDTH=8, RST_VAL=8'hA5; reset=1 -> Q=8'hA5; then reset=0, D=8'h3C -> Q=8'h3C next edge; reset=1 and D=8'hFF on the same edge -> Q=8'hA5 (reset wins).

Source files
------------

// File: rtl/dff_async.sv
// Parameterizable D flip-flop with synchronous active-high reset.
// The "async" in the name is historical only; reset is sampled on the rising clock edge.
`timescale 1ns/1ps
module dff_async #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Reset takes priority; with no enable, Q reloads on every rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= RST_VAL;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_dff_async.sv
// Directed bench for dff_async: a default 1-bit instance and an 8-bit instance
// with a non-zero reset value, checked against hand-computed expectations.
`timescale 1ns/1ps
module tb_dff_async;

    logic       clk;
    logic       rst1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks;
    int errors;

    dff_async u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .D     (d1),
        .Q     (q1)
    );

    dff_async #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (rst8),
        .D     (d8),
        .Q     (q8)
    );

    // 4 ns period: rising edges at 2, 6, 10, ...
    initial clk = 1'b0;
    always #2 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d1 = 1'b1; rst1 = 1'b0;
        tick();
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload: q=%b required 1", q1);
        end else $display("ok reset_preload q=%b", q1);
        rst1 = 1'b1; d1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_load[%0d]: q=%b required 0", i, q1);
            end else $display("ok reset_load[%0d] q=%b", i, q1);
        end
    endtask

    task automatic test_release();
        rst1 = 1'b1; d1 = 1'b1;
        tick();
        tick();
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL release_held: q=%b required 0", q1);
        end else $display("ok release_held q=%b", q1);
        rst1 = 1'b0; d1 = 1'b1;
        #2.5;  // just before the next rising edge
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL release_early: q=%b required 0", q1);
        end else $display("ok release_early q=%b", q1);
        tick();
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL release_load: q=%b required 1", q1);
        end else $display("ok release_load q=%b", q1);
    endtask

    task automatic test_sync_only();
        rst1 = 1'b0; d1 = 1'b1;
        tick();                 // now at rising edge P + 1
        #1.25;                  // P + 2.25, just after the falling edge
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL sync_after_fall: q=%b required 1", q1);
        end else $display("ok sync_after_fall q=%b", q1);
        #0.25 rst1 = 1'b1;      // 1 ns reset pulse entirely between edges
        #0.5;
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL sync_pulse_mid: q=%b required 1", q1);
        end else $display("ok sync_pulse_mid q=%b", q1);
        #0.5 rst1 = 1'b0;
        #0.25;
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL sync_pulse_end: q=%b required 1", q1);
        end else $display("ok sync_pulse_end q=%b", q1);
        tick();
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL sync_next_edge: q=%b required 1", q1);
        end else $display("ok sync_next_edge q=%b", q1);
        // D changes before a falling edge must not reach Q until the rising edge
        d1 = 1'b0;
        #1.5;
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL falling_edge_hold: q=%b required 1", q1);
        end else $display("ok falling_edge_hold q=%b", q1);
        tick();
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL falling_edge_next_rise: q=%b required 0", q1);
        end else $display("ok falling_edge_next_rise q=%b", q1);
    endtask

    task automatic test_alternating();
        logic [3:0] rst_seq = 4'b1010;  // applied MSB first: 1,0,1,0
        logic [3:0] exp_seq = 4'b0101;  // expected Q: 0,1,0,1
        d1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rst1 = rst_seq[3-i];
            tick();
            checks++;
            if (q1 !== exp_seq[3-i]) begin
                errors++;
                $display("FAIL alternating[%0d]: q=%b required %b", i, q1, exp_seq[3-i]);
            end else $display("ok alternating[%0d] reset=%b q=%b", i, rst1, q1);
        end
    endtask

    task automatic test_data_tracking();
        logic [3:0] d_seq = 4'b1001;    // applied MSB first: 1,0,0,1
        logic       prev;
        rst1 = 1'b0;
        d1 = 1'b0;
        tick();
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d1 = d_seq[3-i];
            #0.5 d1 = ~d_seq[3-i];      // mid-cycle glitch
            #1.0 d1 = d_seq[3-i];
            #1.0;                       // 0.5 ns before the next rising edge
            checks++;
            if (q1 !== prev) begin
                errors++;
                $display("FAIL track_hold[%0d]: q=%b required %b", i, q1, prev);
            end else $display("ok track_hold[%0d] q=%b", i, q1);
            tick();
            checks++;
            if (q1 !== d_seq[3-i]) begin
                errors++;
                $display("FAIL track_load[%0d]: q=%b required %b", i, q1, d_seq[3-i]);
            end else $display("ok track_load[%0d] d=%b q=%b", i, d1, q1);
            prev = d_seq[3-i];
        end
    endtask

    task automatic test_param();
        rst8 = 1'b1; d8 = 8'h00;
        tick();
        checks++;
        if (q8 !== 8'hA5) begin
            errors++;
            $display("FAIL param_reset: q=%h required a5", q8);
        end else $display("ok param_reset q=%h", q8);
        rst8 = 1'b0; d8 = 8'h3C;
        tick();
        checks++;
        if (q8 !== 8'h3C) begin
            errors++;
            $display("FAIL param_load: q=%h required 3c", q8);
        end else $display("ok param_load q=%h", q8);
        rst8 = 1'b1; d8 = 8'hFF;
        tick();
        checks++;
        if (q8 !== 8'hA5) begin
            errors++;
            $display("FAIL param_reset_priority: q=%h required a5", q8);
        end else $display("ok param_reset_priority q=%h", q8);
        rst8 = 1'b0; d8 = 8'h5A;
        tick();
        checks++;
        if (q8 !== 8'h5A) begin
            errors++;
            $display("FAIL param_release: q=%h required 5a", q8);
        end else $display("ok param_release q=%h", q8);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst1 = 1'b0; d1 = 1'b0;
        rst8 = 1'b0; d8 = 8'h00;
        test_reset();
        test_release();
        test_sync_only();
        test_alternating();
        test_data_tracking();
        test_param();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
